// File: rtl/latch_ctrl_pkg.sv
// Shared FSM state type, default bank geometry and address-width helper for the latch write arbiter.
package latch_ctrl_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_NL = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_t;

    function automatic int addr_w(input int nl);
        return (nl > 1) ? $clog2(nl) : 1;
    endfunction

endpackage

// File: rtl/latch_wr_arbiter_if.sv
// Two-requester write port plus latch-bank drive bundle.
// master = requester/bank side, slave = arbiter side.
interface latch_wr_arbiter_if
    import latch_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int NL = DEF_NL
);
    localparam int AW = addr_w(NL);

    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          ack0;
    logic          ack1;
    logic          busy;
    logic [DW-1:0] lat_d;
    logic [NL-1:0] lat_en;
    logic          lat_rst;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  ack0, ack1, busy, lat_d, lat_en, lat_rst
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output ack0, ack1, busy, lat_d, lat_en, lat_rst
    );

endinterface

// File: rtl/latch_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer register updated when a grant is taken.
// Latency: 0 cycles req->grant; no backpressure, the caller decides when to take the grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    logic last;

    assign gnt_vld = |req;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (take) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/latch_wr_arbiter.sv
// Arbitrates two write requesters onto a latch bank with a setup/pulse/hold enable sequence.
// Latency: ack 3 cycles after the IDLE grant, one write per 4 cycles; requests held off while busy.
module latch_wr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int NL = DEF_NL
) (
    input logic               clk,
    input logic               rst_n,
    latch_wr_arbiter_if.slave bus
);

    localparam int AW = addr_w(NL);

    state_t        state;
    state_t        state_nxt;
    logic          lat_rst_q;
    logic          gnt_vld;
    logic          gnt_idx;
    logic          take;
    logic          cap_idx;
    logic [AW-1:0] cap_addr;
    logic          addr_ok;
    logic [DW-1:0] lat_d_q;
    logic [NL-1:0] lat_en_q;
    logic [NL-1:0] en_nxt;
    logic          ack0_q;
    logic          ack0_nxt;
    logic          ack1_q;
    logic          ack1_nxt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.req1, bus.req0}),
        .take    (take),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // The edge that releases lat_rst never grants, so the bank clear completes first.
    assign take    = (state == ST_IDLE) && gnt_vld && !lat_rst_q;
    assign addr_ok = 32'(cap_addr) < NL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        en_nxt    = '0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (take) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_PULSE;
                if (addr_ok) begin
                    en_nxt = NL'(1) << cap_addr;
                end
            end
            ST_PULSE: begin
                state_nxt = ST_HOLD;
                ack0_nxt  = !cap_idx;
                ack1_nxt  = cap_idx;
            end
            ST_HOLD: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rst_q <= 1'b1;
            cap_idx   <= 1'b0;
            cap_addr  <= '0;
            lat_d_q   <= '0;
            lat_en_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
        end else begin
            lat_rst_q <= 1'b0;
            lat_en_q  <= en_nxt;
            ack0_q    <= ack0_nxt;
            ack1_q    <= ack1_nxt;
            if (take) begin
                cap_idx  <= gnt_idx;
                cap_addr <= gnt_idx ? bus.addr1 : bus.addr0;
                lat_d_q  <= gnt_idx ? bus.data1 : bus.data0;
            end
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.lat_d   = lat_d_q;
    assign bus.lat_en  = lat_en_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.lat_rst = lat_rst_q;

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// Directed and random stimulus for latch_wr_arbiter against a cycle-schedule reference model.
module tb_latch_wr_arbiter;
    import latch_ctrl_pkg::*;

    localparam int DW = 8;
    localparam int NL = 6;
    localparam int AW = addr_w(NL);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    latch_wr_arbiter_if #(.DW(DW), .NL(NL)) bus ();

    latch_wr_arbiter #(.DW(DW), .NL(NL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: a rolling schedule of expected outputs per future cycle.
    bit            rm_last;
    bit            rm_block;
    bit            rm_lrst;
    int            busy_left;
    logic [DW-1:0] rm_d;
    logic [NL-1:0] s_en   [8];
    bit            s_ack0 [8];
    bit            s_ack1 [8];
    bit            s_busy [8];
    bit            s_setd [8];
    logic [DW-1:0] s_d    [8];
    bit            s_wr   [8];
    logic [AW-1:0] s_wa   [8];
    logic [DW-1:0] s_wd   [8];
    logic [DW-1:0] ref_mem [NL];
    logic [DW-1:0] bank    [NL];
    logic [DW-1:0] prev_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_slot(input int s);
        s_en[s]   = '0;
        s_ack0[s] = 1'b0;
        s_ack1[s] = 1'b0;
        s_busy[s] = 1'b0;
        s_setd[s] = 1'b0;
        s_d[s]    = '0;
        s_wr[s]   = 1'b0;
        s_wa[s]   = '0;
        s_wd[s]   = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) clear_slot(i);
        for (int i = 0; i < NL; i++) ref_mem[i] = '0;
        rm_last   = 1'b1;
        rm_block  = 1'b1;
        rm_lrst   = 1'b1;
        busy_left = 0;
        rm_d      = '0;
    endtask

    // Decide what the coming clock edge does, from the request inputs seen before it.
    task automatic model_edge();
        int            n;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        n = cyc + 1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (busy_left > 0) begin
            busy_left--;
        end else if (!rm_block && (bus.req0 || bus.req1)) begin
            w = (bus.req0 && bus.req1) ? !rm_last : bus.req1;
            rm_last = w;
            a = w ? bus.addr1 : bus.addr0;
            d = w ? bus.data1 : bus.data0;
            for (int k = 0; k < 3; k++) s_busy[(n + k) % 8] = 1'b1;
            s_setd[n % 8] = 1'b1;
            s_d[n % 8]    = d;
            if (32'(a) < NL) begin
                s_en[(n + 1) % 8] = NL'(1) << a;
                s_wr[(n + 2) % 8] = 1'b1;
                s_wa[(n + 2) % 8] = a;
                s_wd[(n + 2) % 8] = d;
            end
            if (w) s_ack1[(n + 2) % 8] = 1'b1;
            else   s_ack0[(n + 2) % 8] = 1'b1;
            busy_left = 3;
        end
        rm_block = 1'b0;
        rm_lrst  = 1'b0;
    endtask

    task automatic compare();
        int s;
        s = cyc % 8;
        if (s_setd[s]) rm_d = s_d[s];
        chk("lat_en",  32'(bus.lat_en),  32'(s_en[s]));
        chk("ack0",    32'(bus.ack0),    32'(s_ack0[s]));
        chk("ack1",    32'(bus.ack1),    32'(s_ack1[s]));
        chk("busy",    32'(bus.busy),    32'(s_busy[s]));
        chk("lat_d",   32'(bus.lat_d),   32'(rm_d));
        chk("lat_rst", 32'(bus.lat_rst), 32'(rm_lrst));
        chk("en_onehot0", 32'($onehot0(bus.lat_en)), 32'd1);
        if (|bus.lat_en) chk("d_stable_at_en", 32'(bus.lat_d), 32'(prev_d));
        prev_d = bus.lat_d;
        if (s_wr[s]) ref_mem[s_wa[s]] = s_wd[s];
        for (int i = 0; i < NL; i++) begin
            if (bus.lat_rst)        bank[i] = '0;
            else if (bus.lat_en[i]) bank[i] = bus.lat_d;
        end
        clear_slot(s);
    endtask

    task automatic step();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        compare();
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_lat_en",  32'(bus.lat_en),  32'd0);
        chk("rst_lat_rst", 32'(bus.lat_rst), 32'd1);
        chk("rst_ack",     32'({bus.ack1, bus.ack0}), 32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_lat_d",   32'(bus.lat_d),   32'd0);
    endtask

    task automatic rnd_req(input logic ack, inout logic req, inout logic [AW-1:0] a,
                           inout logic [DW-1:0] d);
        if (ack) begin
            req = 1'b0;
        end else if (req) begin
            if ($urandom_range(0, 15) == 0) req = 1'b0;
            else if ($urandom_range(0, 7) == 0) begin
                a = AW'($urandom_range(0, 7));
                d = DW'($urandom);
            end
        end else if ($urandom_range(0, 2) == 0) begin
            req = 1'b1;
            a   = AW'($urandom_range(0, 7));
            d   = DW'($urandom);
        end
    endtask

    initial begin
        int who[$];
        int when[$];
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;
        bus.data0 = '0;  bus.data1 = '0;
        prev_d = '0;
        for (int i = 0; i < NL; i++) bank[i] = '0;

        // Power-on reset, then release; the release edge must not grant.
        #1;
        reset_now();
        step(); step();
        rst_n = 1'b1;
        bus.req1 = 1'b1; bus.addr1 = 3'd0; bus.data1 = 8'h10;
        step();
        chk("release_no_grant", 32'(bus.busy), 32'd0);
        bus.req1 = 1'b0;
        step();

        // Single write: addr 3, data A5.
        bus.req0 = 1'b1; bus.addr0 = 3'd3; bus.data0 = 8'hA5;
        step();
        chk("w1_setup_d",  32'(bus.lat_d),  32'hA5);
        chk("w1_setup_en", 32'(bus.lat_en), 32'h00);
        step();
        chk("w1_pulse_en", 32'(bus.lat_en), 32'h08);
        step();
        chk("w1_hold_ack0", 32'(bus.ack0), 32'd1);
        bus.req0 = 1'b0;
        step();
        chk("w1_idle_ack0", 32'(bus.ack0), 32'd0);
        chk("w1_bank3",     32'(bank[3]),  32'hA5);

        // Both requesting continuously: grants alternate, acks 4 cycles apart.
        bus.req0 = 1'b1; bus.addr0 = 3'd1; bus.data0 = 8'h11;
        bus.req1 = 1'b1; bus.addr1 = 3'd2; bus.data1 = 8'h22;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.ack0) begin who.push_back(0); when.push_back(cyc); end
            if (bus.ack1) begin who.push_back(1); when.push_back(cyc); end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("rr_ack_count", 32'(who.size()), 32'd4);
        for (int i = 0; i < who.size(); i++) begin
            chk("rr_order", 32'(who[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("rr_spacing", 32'(when[i] - when[i-1]), 32'd4);
        end
        step();

        // Requester 1 arrives while requester 0 is busy.
        bus.req0 = 1'b1; bus.addr0 = 3'd4; bus.data0 = 8'h3C;
        step();
        bus.req1 = 1'b1; bus.addr1 = 3'd5; bus.data1 = 8'h5A;
        step(); step();
        chk("late_ack0", 32'(bus.ack0), 32'd1);
        bus.req0 = 1'b0;
        step();
        chk("late_idle_busy", 32'(bus.busy), 32'd0);
        step();
        chk("late_setup_d",   32'(bus.lat_d), 32'h5A);
        chk("late_bank5_old", 32'(bank[5]),   32'h00);
        step();
        chk("late_bank5_new", 32'(bank[5]),   32'h5A);
        step();
        chk("late_ack1", 32'(bus.ack1), 32'd1);
        bus.req1 = 1'b0;
        step();

        // Request dropped during SETUP still completes.
        bus.req0 = 1'b1; bus.addr0 = 3'd2; bus.data0 = 8'h77;
        step();
        bus.req0 = 1'b0;
        step();
        chk("drop_pulse_en", 32'(bus.lat_en), 32'h04);
        step();
        chk("drop_ack0", 32'(bus.ack0), 32'd1);
        step();
        chk("drop_bank2", 32'(bank[2]), 32'h77);

        // Out-of-range address: no enable, ack still issued.
        bus.req1 = 1'b1; bus.addr1 = 3'd7; bus.data1 = 8'hEE;
        step(); step();
        chk("oor_pulse_en", 32'(bus.lat_en), 32'h00);
        step();
        chk("oor_ack1", 32'(bus.ack1), 32'd1);
        bus.req1 = 1'b0;
        step();

        // Reset during PULSE aborts the write and re-arms the pointer.
        bus.req0 = 1'b1; bus.addr0 = 3'd1; bus.data0 = 8'h99;
        step(); step();
        chk("abort_pulse_en", 32'(bus.lat_en), 32'h02);
        reset_now();
        bus.req1 = 1'b1; bus.addr1 = 3'd4; bus.data1 = 8'h44;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("abort_release_busy", 32'(bus.busy), 32'd0);
        step();
        chk("abort_tie_d", 32'(bus.lat_d), 32'h99);
        step(); step();
        chk("abort_tie_ack0", 32'(bus.ack0), 32'd1);
        bus.req0 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        bus.req1 = 1'b0;
        step();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            rnd_req(bus.ack0, bus.req0, bus.addr0, bus.data0);
            rnd_req(bus.ack1, bus.req1, bus.addr1, bus.data1);
            if ($urandom_range(0, 399) == 0) begin
                reset_now();
                step(); step();
                rst_n = 1'b1;
            end
            step();
        end

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        for (int i = 0; i < NL; i++) chk("final_bank", 32'(bank[i]), 32'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
